// File: rtl/mips_instruction_fetch_if.sv
// mips_instruction_fetch_if: instruction-side Avalon-MM read bus between fetch stage and memory
interface mips_instruction_fetch_if;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    modport master (output address, read, byteenable, input waitrequest, readdata);
    modport slave (input address, read, byteenable, output waitrequest, readdata);
endinterface

// File: rtl/mips_instruction_fetch.sv
// mips_instruction_fetch: PC-driven instruction fetch with valid/ready hand-off, halt and timeout detection (optional IFETCH_ALIGN_CHECK_EN)
module mips_instruction_fetch #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                pc,
    output logic                       cnt_en,
    mips_instruction_fetch_if.master   bus,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic                       active,
    output logic                       fault,
    output logic [1:0]                 fault_code,
    output logic [CNT_W-1:0]           fetch_count
);
    localparam int WAIT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {FETCH, HOLD, HALTED, FAULT} state_t;
    state_t            state, state_nx;
    logic [31:0]       instr_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [CNT_W-1:0]  count_nx;
    logic              fault_nx;
    logic [1:0]        code_nx;
    logic              in_fetch, misaligned;
    logic [31:0]       fetch_addr;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = pc[1:0] != 2'b00;
    assign fetch_addr = pc;
`else
    assign misaligned = 1'b0;
    assign fetch_addr = {pc[31:2], 2'b00};
`endif
    assign in_fetch        = state == FETCH;
    assign bus.read        = in_fetch && pc != 32'h0 && !misaligned;
    assign bus.address     = in_fetch ? fetch_addr : 32'h0;
    assign bus.byteenable  = bus.read ? 4'hF : 4'h0;
    assign instr_valid     = state == HOLD;
    assign cnt_en          = instr_valid && instr_ready;
    assign active          = in_fetch || instr_valid;
    // next-state and datapath updates; halt beats misalignment, which beats the bus response
    always_comb begin
        state_nx = state;
        instr_nx = instr;
        wait_nx  = '0;
        count_nx = fetch_count;
        fault_nx = fault;
        code_nx  = fault_code;
        case (state)
            FETCH:
                if (pc == 32'h0)
                    state_nx = HALTED;
                else if (misaligned) begin
                    state_nx = FAULT;
                    fault_nx = 1'b1;
                    code_nx  = 2'b10;
                end else if (!bus.waitrequest) begin
                    instr_nx = bus.readdata;
                    state_nx = HOLD;
                end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    state_nx = FAULT;
                    fault_nx = 1'b1;
                    code_nx  = 2'b01;
                end else
                    wait_nx = wait_cnt + WAIT_W'(1);
            HOLD:
                if (instr_ready) begin
                    count_nx = fetch_count + CNT_W'(1);
                    state_nx = FETCH;
                end
            default: ;
        endcase
    end
    // state and datapath registers; reset abandons any read in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            instr       <= 32'h0;
            wait_cnt    <= '0;
            fetch_count <= '0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            state       <= state_nx;
            instr       <= instr_nx;
            wait_cnt    <= wait_nx;
            fetch_count <= count_nx;
            fault       <= fault_nx;
            fault_code  <= code_nx;
        end
    end
endmodule

// File: tb/tb_mips_instruction_fetch.sv
// tb_mips_instruction_fetch: directed and randomized fetch transactions against a transaction-level timing model
module tb_mips_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        cnt_en, instr_valid, active, fault;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [1:0]  fault_code;
  logic [3:0]  fetch_count;
  int          vectors = 0;
  int          errs = 0;
  logic [3:0]  exp_count = 4'h0;
  logic [31:0] exp_instr = 32'h0;
  mips_instruction_fetch_if bus();
  mips_instruction_fetch #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .cnt_en(cnt_en), .bus(bus.master),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .active(active), .fault(fault), .fault_code(fault_code), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef IFETCH_ALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fetch_txn(input logic [31:0] p, input logic [31:0] d, input int w, input int r);
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      pc = p;
      bus.waitrequest = k < w;
      bus.readdata = k < w ? $urandom : d;
      instr_ready = 1'($urandom_range(0, 1));
      #1;
      chk("fetch_read", bus.read, 1'b1);
      chk("fetch_addr", bus.address, exp_addr(p));
      chk("fetch_be", bus.byteenable, 4'hF);
      chk("fetch_valid", instr_valid, 1'b0);
      chk("fetch_cnt_en", cnt_en, 1'b0);
      chk("fetch_active", active, 1'b1);
      chk("fetch_count", fetch_count, exp_count);
      chk("fetch_fault", fault, 1'b0);
    end
    exp_instr = d;
    for (int k = 0; k <= r; k++) begin
      @(negedge clk);
      instr_ready = k == r;
      bus.waitrequest = 1'($urandom_range(0, 1));
      bus.readdata = $urandom;
      #1;
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_instr", instr, exp_instr);
      chk("hold_cnt_en", cnt_en, 1'(k == r));
      chk("hold_read", bus.read, 1'b0);
      chk("hold_addr", bus.address, 32'h0);
      chk("hold_count", fetch_count, exp_count);
    end
    exp_count++;
  endtask
  initial begin
    logic [31:0] p;
    bus.waitrequest = 1'b0;
    bus.readdata = 32'h0;
    #1 rst = 1'b0;
    pc = 32'hBFC0_0000;
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_active", active, 1'b1);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_count", fetch_count, 4'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", fault_code, 2'b00);
    @(posedge clk);
    #1 rst = 1'b1;
    fetch_txn(32'hBFC0_0000, 32'h2402_0005, 0, 0);
    @(posedge clk);
    #1;
    chk("first_count", fetch_count, exp_count);
    fetch_txn(32'hBFC0_0004, 32'h2403_0007, 3, 0);
    fetch_txn(32'hBFC0_0008, 32'h0043_2020, 0, 5);
    for (int i = 0; i < 20; i++) begin
      p = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
      p[1:0] = 2'b00;
`endif
      if (p == 32'h0) p = 32'h100;
      fetch_txn(p, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pc = 32'h8000_0040;
      bus.waitrequest = 1'b1;
      #1;
      chk("to_read", bus.read, 1'b1);
      chk("to_addr", bus.address, 32'h8000_0040);
      chk("to_nofault", fault, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.waitrequest = 1'($urandom_range(0, 1));
      instr_ready = 1'b1;
      #1;
      chk("to_fault", fault, 1'b1);
      chk("to_code", fault_code, 2'b01);
      chk("to_read_off", bus.read, 1'b0);
      chk("to_active", active, 1'b0);
      chk("to_valid", instr_valid, 1'b0);
      chk("to_count", fetch_count, exp_count);
      chk("to_instr", instr, exp_instr);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.waitrequest = 1'b0;
    #1;
    exp_count = 4'h0;
    exp_instr = 32'h0;
    chk("rerst_fault", fault, 1'b0);
    chk("rerst_code", fault_code, 2'b00);
    chk("rerst_active", active, 1'b1);
    chk("rerst_count", fetch_count, exp_count);
    chk("rerst_instr", instr, exp_instr);
    @(posedge clk);
    #1 rst = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
    @(negedge clk);
    pc = 32'hBFC0_0002;
    #1;
    chk("mis_read", bus.read, 1'b0);
    @(negedge clk);
    #1;
    chk("mis_fault", fault, 1'b1);
    chk("mis_code", fault_code, 2'b10);
    chk("mis_active", active, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
`else
    fetch_txn(32'hBFC0_0002, 32'h8C43_0004, 0, 1);
`endif
    @(negedge clk);
    pc = 32'h0;
    #1;
    chk("halt_read", bus.read, 1'b0);
    chk("halt_active_now", active, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      instr_ready = 1'(k % 2);
      bus.readdata = $urandom;
      #1;
      chk("halt_active", active, 1'b0);
      chk("halt_read_off", bus.read, 1'b0);
      chk("halt_be", bus.byteenable, 4'h0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_cnt_en", cnt_en, 1'b0);
      chk("halt_instr", instr, exp_instr);
      chk("halt_count", fetch_count, exp_count);
      chk("halt_fault", fault, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
